// File: rtl/id_exe_skid_reg.sv
// ID->EXE pipeline register with a two-entry skid buffer, synchronous flush and
// saturating stall/flush statistics. id_ready is registered so EXE never sees a combinational path to ID.
module id_exe_skid_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int ALUC_W = 4,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [4:0]        id_ctrl,
    input  logic [ALUC_W-1:0] id_aluc,
    input  logic [DATA_W-1:0] id_data_a,
    input  logic [DATA_W-1:0] id_data_b,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_regrt,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [TAG_W-1:0]  id_ins_type,
    input  logic [TAG_W-1:0]  id_ins_number,
    output logic              exe_valid,
    input  logic              exe_ready,
    output logic [4:0]        e_ctrl,
    output logic [ALUC_W-1:0] e_aluc,
    output logic [DATA_W-1:0] e_data_a,
    output logic [DATA_W-1:0] e_data_b,
    output logic [DATA_W-1:0] e_imm,
    output logic              e_regrt,
    output logic [REG_W-1:0]  e_rt,
    output logic [REG_W-1:0]  e_rd,
    output logic [TAG_W-1:0]  e_ins_type,
    output logic [TAG_W-1:0]  e_ins_number,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic [4:0]        ctrl;
        logic [ALUC_W-1:0] aluc;
        logic [DATA_W-1:0] data_a;
        logic [DATA_W-1:0] data_b;
        logic [DATA_W-1:0] imm;
        logic              regrt;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [TAG_W-1:0]  ins_type;
        logic [TAG_W-1:0]  ins_number;
    } payload_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

    state_e           state_q, state_d;
    payload_t         in_pl, main_q, main_d, skid_q, skid_d;
    logic             id_ready_q;
    logic             in_fire, out_fire, skid_valid;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    assign in_pl = '{ctrl: id_ctrl, aluc: id_aluc, data_a: id_data_a, data_b: id_data_b,
                     imm: id_imm, regrt: id_regrt, rt: id_rt, rd: id_rd,
                     ins_type: id_ins_type, ins_number: id_ins_number};

    assign exe_valid  = (state_q != EMPTY);
    assign skid_valid = (state_q == FULL);
    assign in_fire    = id_valid && id_ready_q;
    assign out_fire   = exe_valid && exe_ready;

    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (in_fire) begin
                    main_d  = in_pl;
                    state_d = ONE;
                end
                ONE: if (in_fire && out_fire) begin
                    main_d = in_pl;
                end else if (in_fire) begin
                    skid_d  = in_pl;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
                FULL: if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Stall is counted even in a flush cycle; both counters stick at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (exe_valid && !exe_ready && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush && exe_valid && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            id_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            id_ready_q  <= (state_d != FULL);
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // NOTE: payload regs are reset so e_* read as zero, not X, before the first transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign id_ready     = id_ready_q;
    assign e_ctrl       = exe_valid ? main_q.ctrl : 5'b0;
    assign e_aluc       = main_q.aluc;
    assign e_data_a     = main_q.data_a;
    assign e_data_b     = main_q.data_b;
    assign e_imm        = main_q.imm;
    assign e_regrt      = main_q.regrt;
    assign e_rt         = main_q.rt;
    assign e_rd         = main_q.rd;
    assign e_ins_type   = main_q.ins_type;
    assign e_ins_number = main_q.ins_number;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

    // skid_valid exists for readability of the state mapping; keep it observable in sim.
    logic skid_valid_unused;
    assign skid_valid_unused = skid_valid;

endmodule

// File: tb/tb_id_exe_skid_reg.sv
// Directed bench for id_exe_skid_reg: streaming, stall/skid, flush, async reset,
// counter saturation (narrow-counter instance) and a random run against a queue model.
module tb_id_exe_skid_reg;

    logic        clk, rst_n, flush, id_valid, exe_ready;
    logic [4:0]  id_ctrl, id_rt, id_rd;
    logic [3:0]  id_aluc, id_ins_type, id_ins_number;
    logic [31:0] id_data_a, id_data_b, id_imm;
    logic        id_regrt;

    logic        id_ready, exe_valid, e_regrt;
    logic [4:0]  e_ctrl, e_rt, e_rd;
    logic [3:0]  e_aluc, e_ins_type, e_ins_number;
    logic [31:0] e_data_a, e_data_b, e_imm;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_id_valid, s_exe_ready, s_flush;
    logic        s_id_ready, s_exe_valid, s_e_regrt;
    logic [4:0]  s_e_ctrl, s_e_rt, s_e_rd;
    logic [3:0]  s_e_aluc, s_e_ins_type, s_e_ins_number;
    logic [31:0] s_e_data_a, s_e_data_b, s_e_imm;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    id_exe_skid_reg dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_ctrl(id_ctrl), .id_aluc(id_aluc), .id_data_a(id_data_a), .id_data_b(id_data_b),
        .id_imm(id_imm), .id_regrt(id_regrt), .id_rt(id_rt), .id_rd(id_rd),
        .id_ins_type(id_ins_type), .id_ins_number(id_ins_number),
        .exe_valid(exe_valid), .exe_ready(exe_ready),
        .e_ctrl(e_ctrl), .e_aluc(e_aluc), .e_data_a(e_data_a), .e_data_b(e_data_b),
        .e_imm(e_imm), .e_regrt(e_regrt), .e_rt(e_rt), .e_rd(e_rd),
        .e_ins_type(e_ins_type), .e_ins_number(e_ins_number),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow counters make saturation reachable in a few cycles.
    id_exe_skid_reg #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(s_flush),
        .id_valid(s_id_valid), .id_ready(s_id_ready),
        .id_ctrl(id_ctrl), .id_aluc(id_aluc), .id_data_a(id_data_a), .id_data_b(id_data_b),
        .id_imm(id_imm), .id_regrt(id_regrt), .id_rt(id_rt), .id_rd(id_rd),
        .id_ins_type(id_ins_type), .id_ins_number(id_ins_number),
        .exe_valid(s_exe_valid), .exe_ready(s_exe_ready),
        .e_ctrl(s_e_ctrl), .e_aluc(s_e_aluc), .e_data_a(s_e_data_a), .e_data_b(s_e_data_b),
        .e_imm(s_e_imm), .e_regrt(s_e_regrt), .e_rt(s_e_rt), .e_rd(s_e_rd),
        .e_ins_type(s_e_ins_type), .e_ins_number(s_e_ins_number),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        check(tag, {127'b0, obs}, {127'b0, exp});
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        check(tag, {112'b0, obs}, {112'b0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] v);
        id_ctrl       = v[4:0] ^ 5'h15;
        id_aluc       = v[3:0];
        id_data_a     = v;
        id_data_b     = v ^ 32'hA5A5_0000;
        id_imm        = v * 32'd3;
        id_regrt      = v[0];
        id_rt         = v[4:0];
        id_rd         = v[9:5];
        id_ins_type   = v[3:0] ^ 4'h9;
        id_ins_number = v[7:4];
    endtask

    function automatic logic [127:0] exp_pl(input logic [31:0] v);
        logic [31:0] imm;
        imm = v * 32'd3;
        return {4'h0, v[4:0] ^ 5'h15, v[3:0], v, v ^ 32'hA5A5_0000, imm,
                v[0], v[4:0], v[9:5], v[3:0] ^ 4'h9, v[7:4]};
    endfunction

    function automatic logic [127:0] obs_pl();
        return {4'h0, e_ctrl, e_aluc, e_data_a, e_data_b, e_imm,
                e_regrt, e_rt, e_rd, e_ins_type, e_ins_number};
    endfunction

    logic [31:0] q[$];
    logic [31:0] seq;
    logic [15:0] m_stall, m_flush;

    initial begin
        rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0; exe_ready = 1'b1;
        s_id_valid = 1'b1; s_exe_ready = 1'b0; s_flush = 1'b0;
        set_in(32'h0);
        tick(); tick();

        // Reset state
        check1("rst_exe_valid", exe_valid, 1'b0);
        check1("rst_id_ready", id_ready, 1'b1);
        check("rst_e_ctrl", {123'b0, e_ctrl}, 128'h0);
        check("rst_e_data_a", {96'b0, e_data_a}, 128'h0);
        check16("rst_stall_cnt", stall_cnt, 16'h0);
        check16("rst_flush_cnt", flush_cnt, 16'h0);
        rst_n = 1'b1;

        // 1: single transfer then back-to-back stream
        id_valid = 1'b1; set_in(32'h1234);
        tick();
        check1("t1_exe_valid", exe_valid, 1'b1);
        check("t1_payload", obs_pl(), exp_pl(32'h1234));
        for (int i = 0; i < 8; i++) begin
            set_in(32'd100 + 32'(i));
            tick();
            check1("t1_stream_valid", exe_valid, 1'b1);
            check1("t1_stream_ready", id_ready, 1'b1);
            check("t1_stream_payload", obs_pl(), exp_pl(32'd100 + 32'(i)));
        end
        id_valid = 1'b0;
        tick();
        check1("t1_drained", exe_valid, 1'b0);
        check16("t1_stall_cnt", stall_cnt, 16'h0);

        // 2: stall fills main then skid; third instruction waits at ID
        exe_ready = 1'b0; id_valid = 1'b1; set_in(32'd200);
        tick();
        check("t2_main200", obs_pl(), exp_pl(32'd200));
        check1("t2_ready_one", id_ready, 1'b1);
        set_in(32'd201);
        tick();
        check1("t2_ready_full", id_ready, 1'b0);
        set_in(32'd202);
        tick();
        check("t2_hold200", obs_pl(), exp_pl(32'd200));
        check1("t2_still_full", id_ready, 1'b0);
        check16("t2_stall2", stall_cnt, 16'd2);
        exe_ready = 1'b1;
        tick();
        check("t2_out201", obs_pl(), exp_pl(32'd201));
        check1("t2_ready_back", id_ready, 1'b1);
        tick();
        check("t2_out202", obs_pl(), exp_pl(32'd202));
        id_valid = 1'b0;
        tick();
        check1("t2_drained", exe_valid, 1'b0);
        check16("t2_stall_final", stall_cnt, 16'd2);

        // 3: flush while FULL with a new offer
        exe_ready = 1'b0; id_valid = 1'b1; set_in(32'd300);
        tick();
        set_in(32'd301);
        tick();
        check1("t3_full", id_ready, 1'b0);
        flush = 1'b1; set_in(32'd302);
        tick();
        flush = 1'b0; id_valid = 1'b0; exe_ready = 1'b1;
        check1("t3_exe_valid", exe_valid, 1'b0);
        check("t3_e_ctrl", {123'b0, e_ctrl}, 128'h0);
        check1("t3_id_ready", id_ready, 1'b1);
        check16("t3_flush_cnt", flush_cnt, 16'd1);
        check16("t3_stall_cnt", stall_cnt, 16'd4);
        check("t3_payload_hold", {96'b0, e_data_a}, {96'b0, 32'd300});
        tick();
        check1("t3_no_ghost", exe_valid, 1'b0);
        id_valid = 1'b1; set_in(32'd303);
        tick();
        check("t3_after_flush", obs_pl(), exp_pl(32'd303));
        id_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check16("t3_empty_flush", flush_cnt, 16'd1);

        // 4: async reset while FULL
        exe_ready = 1'b0; id_valid = 1'b1; set_in(32'd400);
        tick();
        set_in(32'd401);
        tick();
        check1("t4_full", id_ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check1("t4_rst_valid", exe_valid, 1'b0);
        check1("t4_rst_ready", id_ready, 1'b1);
        check("t4_rst_payload", obs_pl(), 128'h0);
        check16("t4_rst_stall", stall_cnt, 16'h0);
        tick();
        rst_n = 1'b1; exe_ready = 1'b1; set_in(32'd500);
        tick();
        check1("t4_new_valid", exe_valid, 1'b1);
        check("t4_new_payload", obs_pl(), exp_pl(32'd500));
        check1("t4_new_ready", id_ready, 1'b1);
        id_valid = 1'b0;
        tick();

        // 5: saturation on the 4-bit instance (always stalled since reset release)
        repeat (20) tick();
        check("t5_stall_sat", {124'b0, s_stall_cnt}, {124'b0, 4'hF});
        repeat (5) tick();
        check("t5_stall_hold", {124'b0, s_stall_cnt}, {124'b0, 4'hF});
        for (int i = 0; i < 20; i++) begin
            s_flush = 1'b1;
            tick();
            s_flush = 1'b0;
            tick();
            if (i == 2)
                check("t5_flush3", {124'b0, s_flush_cnt}, {124'b0, 4'd3});
        end
        check("t5_flush_sat", {124'b0, s_flush_cnt}, {124'b0, 4'hF});

        // 6: random traffic against a queue model
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        seq = 32'h8000; m_stall = '0; m_flush = '0;
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            id_valid  = ($urandom_range(99) < 60);
            exe_ready = ($urandom_range(99) < 60);
            flush     = ($urandom_range(99) < 3);
            set_in(seq);
            #1;
            check1("t6_id_ready", id_ready, q.size() < 2);
            check1("t6_exe_valid", exe_valid, q.size() != 0);
            if (q.size() != 0 && !exe_ready) m_stall++;
            if (q.size() != 0 && flush) m_flush++;
            if (q.size() != 0 && exe_ready) begin
                check("t6_order", obs_pl(), exp_pl(q[0]));
                void'(q.pop_front());
            end
            if (flush) q.delete();
            else if (id_valid && id_ready) q.push_back(seq);
            if (id_valid && id_ready) seq++;
            tick();
        end
        check16("t6_stall_cnt", stall_cnt, m_stall);
        check16("t6_flush_cnt", flush_cnt, m_flush);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
